// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 1280x1024@60 constants, sync polarity, window helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package vga_pkg;

    // Horizontal defaults (pixels), 108 MHz pixel clock
    localparam int unsigned H_VIS_DEF  = 1280;
    localparam int unsigned H_FP_DEF   = 48;
    localparam int unsigned H_SYNC_DEF = 112;
    localparam int unsigned H_BP_DEF   = 248;

    // Vertical defaults (lines)
    localparam int unsigned V_VIS_DEF  = 1024;
    localparam int unsigned V_FP_DEF   = 1;
    localparam int unsigned V_SYNC_DEF = 3;
    localparam int unsigned V_BP_DEF   = 38;

    // Active level of hsync/vsync
    localparam bit SYNC_POL_DEF = 1'b1;

    // Counters and addresses are 16-bit unsigned throughout the video pipe
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned ADDR_MAX = 65535;

    // Half-open window test: lo <= c < hi
    function automatic logic in_window(input logic [ADDR_W-1:0] c,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter with enable, terminal count, registered sync decode.
// Latency: cnt_o/sync_o update on the edge after en_i; *_nxt_o are combinational next-state decodes.
// Backpressure: none, free-running when en_i is high.
//
// Ports:
//   clk_i      pixel clock
//   rst_i      synchronous active-high reset; parks the counter at TOTAL-1, sync inactive
//   en_i       advance the counter this cycle
//   cnt_o      current position, 0..TOTAL-1
//   tc_o       current position is TOTAL-1 (used to advance the next axis)
//   tc_nxt_o   next position will be TOTAL-1
//   vis_nxt_o  next position lies in the visible area
//   sync_o     registered sync level for the current position
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = 1688,
    parameter int unsigned VIS        = 1280,
    parameter int unsigned SYNC_START = 1328,
    parameter int unsigned SYNC_LEN   = 112,
    parameter bit          SYNC_POL   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              tc_o,
    output logic              tc_nxt_o,
    output logic              vis_nxt_o,
    output logic              sync_o
);

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] VIS_END = ADDR_W'(VIS);
    localparam logic [ADDR_W-1:0] SYN_LO  = ADDR_W'(SYNC_START);
    localparam logic [ADDR_W-1:0] SYN_HI  = ADDR_W'(SYNC_START + SYNC_LEN);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              sync_q, sync_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Sync is decoded from the next count so it lines up with cnt_o after the edge
    assign sync_d = in_window(cnt_d, SYN_LO, SYN_HI) ? SYNC_POL : ~SYNC_POL;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= LAST;
            sync_q <= ~SYNC_POL;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign tc_o      = (cnt_q == LAST);
    assign tc_nxt_o  = (cnt_d == LAST);
    assign vis_nxt_o = (cnt_d < VIS_END);
    assign sync_o    = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v position, syncs, visible flag, frame-start pulse, frame counter.
// Latency: all outputs registered and mutually aligned; reset takes effect on the next px_clk edge.
// Backpressure: none, free-running raster.
//
// Ports:
//   px_clk       pixel clock
//   rst          synchronous active-high reset
//   h_addr       current column 0..H_TOTAL-1
//   v_addr       current line 0..V_TOTAL-1
//   hsync/vsync  sync outputs, active level SYNC_POL
//   video_on     high inside the visible area
//   screenbegin  one-cycle pulse on the last pixel of each frame
//   frame_cnt    frames completed since reset, wraps at 16 bits
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS    = H_VIS_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_VIS    = V_VIS_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_POL = SYNC_POL_DEF
) (
    input  logic              px_clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] h_addr,
    output logic [ADDR_W-1:0] v_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              screenbegin,
    output logic [ADDR_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > ADDR_MAX) || (V_TOTAL > ADDR_MAX)) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 65535");
    end

    logic h_tc, h_tc_nxt, h_vis_nxt;
    logic v_tc, v_tc_nxt, v_vis_nxt;

    // Column counter runs every cycle
    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VIS        (H_VIS),
        .SYNC_START (H_VIS + H_FP),
        .SYNC_LEN   (H_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_h_cnt (
        .clk_i     (px_clk),
        .rst_i     (rst),
        .en_i      (1'b1),
        .cnt_o     (h_addr),
        .tc_o      (h_tc),
        .tc_nxt_o  (h_tc_nxt),
        .vis_nxt_o (h_vis_nxt),
        .sync_o    (hsync)
    );

    // Line counter advances only on the cycle the column counter wraps
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VIS        (V_VIS),
        .SYNC_START (V_VIS + V_FP),
        .SYNC_LEN   (V_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_v_cnt (
        .clk_i     (px_clk),
        .rst_i     (rst),
        .en_i      (h_tc),
        .cnt_o     (v_addr),
        .tc_o      (v_tc),
        .tc_nxt_o  (v_tc_nxt),
        .vis_nxt_o (v_vis_nxt),
        .sync_o    (vsync)
    );

    logic              video_on_q, video_on_d;
    logic              sb_q, sb_d;
    logic [ADDR_W-1:0] frame_q, frame_d;

    // Both axes decode from their next-state counts, so these land with h_addr/v_addr
    assign video_on_d = h_vis_nxt & v_vis_nxt;
    assign sb_d       = h_tc_nxt & v_tc_nxt;
    assign frame_d    = sb_q ? frame_q + 1'b1 : frame_q;

    always_ff @(posedge px_clk) begin
        if (rst) begin
            video_on_q <= 1'b0;
            sb_q       <= 1'b0;
            frame_q    <= '0;
        end else begin
            video_on_q <= video_on_d;
            sb_q       <= sb_d;
            frame_q    <= frame_d;
        end
    end

    assign video_on    = video_on_q;
    assign screenbegin = sb_q;
    assign frame_cnt   = frame_q;

    // v_tc is only needed by the counter itself; kept visible for debug taps
    logic unused_v_tc;
    assign unused_v_tc = v_tc;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        von;
        logic        sb;
        logic [15:0] fc;
    } obs_t;

    localparam int NCYC = 4000;

    // Small configuration
    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VV = 4, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_FT = 16 * 7;

    logic        px_clk;
    logic        rst_d, rst_s;
    logic [15:0] d_h, d_v, d_fc, s_h, s_v, s_fc;
    logic        d_hs, d_vs, d_von, d_sb, s_hs, s_vs, s_von, s_sb;

    int n_vec  = 0;
    int n_fail = 0;

    obs_t q_def[$];
    obs_t q_sml[$];

    vga_timing_gen dut_def (
        .px_clk(px_clk), .rst(rst_d), .h_addr(d_h), .v_addr(d_v),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .screenbegin(d_sb), .frame_cnt(d_fc)
    );

    vga_timing_gen #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0)
    ) dut_sml (
        .px_clk(px_clk), .rst(rst_s), .h_addr(s_h), .v_addr(s_v),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .screenbegin(s_sb), .frame_cnt(s_fc)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    // Raster model: k = pixel clocks since the first post-reset edge (k=0 is pixel (0,0))
    function automatic obs_t ref_model(input int hv, input int hf, input int hsw, input int hb,
                                       input int vv, input int vf, input int vsw, input int vb,
                                       input bit pol, input bit in_rst, input longint k);
        obs_t   o;
        longint ht, vt, ft, p, h, v;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        ft = ht * vt;
        if (in_rst) begin
            o.h = 16'(ht - 1); o.v = 16'(vt - 1);
            o.hs = ~pol; o.vs = ~pol; o.von = 1'b0; o.sb = 1'b0; o.fc = 16'd0;
        end else begin
            p = k % ft;
            h = p % ht;
            v = p / ht;
            o.h   = 16'(h);
            o.v   = 16'(v);
            o.von = (h < hv) && (v < vv);
            o.hs  = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
            o.vs  = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
            o.sb  = (p == ft - 1);
            o.fc  = 16'((k / ft) % 65536);
        end
        return o;
    endfunction

    // Stimulus: drive resets, push the expected state after the coming edge
    initial begin : stim
        longint kd, ks;
        bit     pd, ps;
        kd = 0; ks = 0; pd = 1'b1; ps = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            rst_d = (c < 5);
            rst_s = (c < 5) || (c == 5 + S_FT + 38) ||
                    (c > 600 && $urandom_range(0, 299) == 0);
            if (rst_d) begin
                pd = 1'b1;
            end else begin
                kd = pd ? 0 : kd + 1;
                pd = 1'b0;
            end
            if (rst_s) begin
                ps = 1'b1;
            end else begin
                ks = ps ? 0 : ks + 1;
                ps = 1'b0;
            end
            q_def.push_back(ref_model(1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, rst_d, kd));
            q_sml.push_back(ref_model(S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                                      1'b0, rst_s, ks));
            @(negedge px_clk);
        end
    end

    task automatic check_obs(input string name, input int cyc, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got h=%0d v=%0d hs=%b vs=%b von=%b sb=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b von=%b sb=%b fc=%0d",
                     name, cyc, got.h, got.v, got.hs, got.vs, got.von, got.sb, got.fc,
                     exp.h, exp.v, exp.hs, exp.vs, exp.von, exp.sb, exp.fc);
        end
    endtask

    task automatic check_int(input string name, input int cyc, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, exp);
        end
    endtask

    // Monitor: pop and compare every presented cycle, plus run-length timing checks
    initial begin : mon
        obs_t gd, gs, ed, es;
        int   d_hrun, d_vonrun, s_vrun, s_last_sb;
        d_hrun = 0; d_vonrun = 0; s_vrun = 0; s_last_sb = -1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge px_clk);
            #1;
            gd = '{h: d_h, v: d_v, hs: d_hs, vs: d_vs, von: d_von, sb: d_sb, fc: d_fc};
            gs = '{h: s_h, v: s_v, hs: s_hs, vs: s_vs, von: s_von, sb: s_sb, fc: s_fc};
            if (q_def.size() == 0 || q_sml.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL scoreboard_empty cyc=%0d got=%0d want=1", c, q_def.size());
            end else begin
                ed = q_def.pop_front();
                es = q_sml.pop_front();
                check_obs("default", c, gd, ed);
                check_obs("small", c, gs, es);
            end

            // Default: hsync active run 112, visible run 1280
            if (rst_d) begin
                d_hrun = 0; d_vonrun = 0;
            end else begin
                if (gd.hs) d_hrun++;
                else if (d_hrun > 0) begin check_int("def_hsync_width", c, d_hrun, 112); d_hrun = 0; end
                if (gd.von) d_vonrun++;
                else if (d_vonrun > 0) begin check_int("def_video_width", c, d_vonrun, 1280); d_vonrun = 0; end
            end

            // Small: vsync (active low) run of one 16-pixel line, frame period 112
            if (rst_s) begin
                s_vrun = 0; s_last_sb = -1;
            end else begin
                if (!gs.vs) s_vrun++;
                else if (s_vrun > 0) begin check_int("sml_vsync_width", c, s_vrun, 16); s_vrun = 0; end
                if (gs.sb) begin
                    if (s_last_sb >= 0) check_int("sml_frame_period", c, c - s_last_sb, S_FT);
                    s_last_sb = c;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The parameter list SHALL include the horizontal timing parameters below (defaults = 1280x1024@60, 108 MHz px_clk).
- H_VIS, 1280, visible pixels per line
- H_FP, 48, horizontal front porch
- H_SYNC, 112, hsync width
- H_BP, 248, horizontal back porch
REQ-002 The parameter list SHALL include the vertical and polarity parameters below.
- V_VIS, 1024, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 3, vsync width
- V_BP, 38, vertical back porch
- SYNC_POL, 1, active level of hsync/vsync
REQ-003 Derived totals SHALL be H_TOTAL = sum of the H parameters (1688) and V_TOTAL = sum of the V parameters (1066).
REQ-004 The ports SHALL be as follows; there is one clock, and reset is synchronous, active-high:
- px_clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- h_addr  out  16  current column, 0..H_TOTAL-1
- v_addr  out  16  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high inside the visible area
- screenbegin  out  1  one-cycle pulse, last pixel of frame
- frame_cnt  out  16  frames completed since reset

Function
REQ-005 h_addr SHALL increment by 1 each px_clk and wrap from H_TOTAL-1 to 0.
REQ-006 v_addr SHALL increment by 1 only on the cycle where h_addr wraps, and SHALL wrap from V_TOTAL-1 to 0 when both counters are at their maximum.
REQ-007 Every output SHALL be a register; hsync, vsync, video_on and screenbegin SHALL describe the same (h_addr, v_addr) value presented in the same cycle, decoded from the next-state counters, with zero skew between outputs.
REQ-008 video_on SHALL be 1 iff h_addr < H_VIS and v_addr < V_VIS.
REQ-009 hsync SHALL equal SYNC_POL iff H_VIS+H_FP <= h_addr < H_VIS+H_FP+H_SYNC (default columns 1328..1439), and ~SYNC_POL otherwise.
REQ-010 vsync SHALL equal SYNC_POL iff V_VIS+V_FP <= v_addr < V_VIS+V_FP+V_SYNC (default lines 1025..1027, entire lines), and ~SYNC_POL otherwise.
REQ-011 screenbegin SHALL be 1 for exactly one cycle per frame, when h_addr = H_TOTAL-1 and v_addr = V_TOTAL-1, so that downstream sprite position latches take effect before pixel (0,0).
REQ-012 frame_cnt SHALL increment by 1 on each clock edge where screenbegin is 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-013 Counter arithmetic SHALL be unsigned 16-bit; parameters SHALL satisfy H_TOTAL, V_TOTAL <= 65535, and this SHALL be checked at elaboration.

Reset
REQ-014 While rst=1, the outputs SHALL be held at: h_addr=H_TOTAL-1, v_addr=V_TOTAL-1, video_on=0, hsync=vsync=~SYNC_POL, screenbegin=0, frame_cnt=0.
REQ-015 On the first px_clk edge with rst=0, the outputs SHALL be h_addr=0, v_addr=0, video_on=1, with frame_cnt unchanged at 0.
REQ-016 Reset asserted mid-frame SHALL take effect on the next edge, with no partial sync pulse and no screenbegin pulse emitted.

Structure
REQ-017 The default timing constants and a SYNC_POL default SHALL live in the shared package vga_pkg, for reuse by the sprite and colour-mux stages.
REQ-018 One sub-module, vga_axis_counter, SHALL be instantiated twice (H and V); it SHALL provide a wrapping counter with an enable input, a terminal-count output and a registered sync/visible window decode.

Verification
REQ-019 Reset check: rst high 5 cycles, then low -> during reset h_addr=1687, v_addr=1065, video_on=0, hsync=vsync=0; on the first edge after release, h_addr=0, v_addr=0, video_on=1.
REQ-020 Line timing: run one line -> hsync high exactly at h_addr 1328..1439 (112 cycles); video_on high at h_addr 0..1279 only; line period = 1688 cycles.
REQ-021 Frame timing: run two frames -> vsync high for exactly 3x1688 = 5064 consecutive cycles starting at v_addr=1025, h_addr=0; frame period = 1,799,408 cycles.
REQ-022 screenbegin: across three frames -> exactly one pulse per frame, at (1687,1065); frame_cnt reads 1, 2, 3 at the following (0,0).
REQ-023 Mid-frame reset: assert rst at (700,500) for 1 cycle -> no screenbegin pulse; the sequence restarts at (0,0) and frame_cnt=0.
REQ-024 Parameter override: H_VIS=8, H_FP=2, H_SYNC=3, H_BP=3, V_VIS=4, V_FP=1, V_SYNC=1, V_BP=1, SYNC_POL=0 -> hsync low at h_addr 10..12; frame period = 16x7 = 112 cycles.
